// File: rtl/lc3_mem_arb.sv
// lc3_mem_arb: round-robin CPU/loader arbiter and wait-state sequencer for the shared LC-3 memory; cpu_*/ldr_* are the two request/ready ports, mem_* drives the array, grant_ldr flags loader ownership
module lc3_mem_arb #(
  parameter int MEM_LATENCY = 4,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ready,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant_ldr
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_owner, r_last, r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata;
  logic          w_pick_ldr;
  assign w_pick_ldr = ldr_req & ~(cpu_req & r_last);
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (r_state == IDLE) begin
      if (cpu_req | ldr_req) begin
        r_state <= ACCESS;
        r_cnt   <= 4'(MEM_LATENCY - 1);
        r_owner <= w_pick_ldr;
        r_last  <= w_pick_ldr;
        r_we    <= w_pick_ldr ? ldr_we : cpu_we;
        r_addr  <= w_pick_ldr ? ldr_addr : cpu_addr;
        r_wdata <= w_pick_ldr ? ldr_wdata : cpu_wdata;
      end
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd0) begin
        r_state <= RESP;
        if (!r_we) r_rdata <= mem_rdata;
      end
    end else
      r_state <= IDLE;
  assign mem_en    = r_state == ACCESS;
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_ready = (r_state == RESP) & ~r_owner;
  assign ldr_ready = (r_state == RESP) & r_owner;
  assign cpu_rdata = r_rdata;
  assign ldr_rdata = r_rdata;
  assign grant_ldr = (r_state != IDLE) & r_owner;
endmodule

// File: tb/tb_lc3_mem_arb.sv
// tb_lc3_mem_arb: randomized arbiter bench against a transaction-level schedule model
module tb_lc3_mem_arb;
  localparam int L = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] req = '0, we = '0, rdy;
  logic [15:0] addr [2], wdata [2];
  logic [15:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_en, mem_we, grant_ldr;
  logic l1_req = 1'b0;
  logic [15:0] m1_addr, m1_wdata, m1_rdata, l1_rdata, c1_rdata;
  logic m1_en, m1_we, l1_ready, c1_ready, g1_ldr;
  lc3_mem_arb #(.MEM_LATENCY(L)) u4 (
    .clk(clk), .rst(rst),
    .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]),
    .cpu_ready(rdy[0]), .cpu_rdata(cpu_rdata),
    .ldr_req(req[1]), .ldr_we(we[1]), .ldr_addr(addr[1]), .ldr_wdata(wdata[1]),
    .ldr_ready(rdy[1]), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_ldr(grant_ldr)
  );
  lc3_mem_arb #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(16'h0000), .cpu_wdata(16'h0000),
    .cpu_ready(c1_ready), .cpu_rdata(c1_rdata),
    .ldr_req(l1_req), .ldr_we(1'b0), .ldr_addr(16'h0010), .ldr_wdata(16'h0000),
    .ldr_ready(l1_ready), .ldr_rdata(l1_rdata),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .grant_ldr(g1_ldr)
  );
  assign m1_rdata = (m1_addr == 16'h0010) ? 16'h00AA : 16'hDEAD;
  logic [15:0] env_mem [0:65535];
  bit env_v [0:65535];
  logic pre_en = 1'b0;
  logic [15:0] pre_addr = '0, pre_data = '0;
  assign mem_rdata = env_v[mem_addr] ? env_mem[mem_addr] : (mem_addr ^ 16'hA5C3);
  always @(posedge clk)
    if (mem_en && mem_we) begin
      env_mem[mem_addr] <= mem_wdata;
      env_v[mem_addr] <= 1'b1;
    end else if (pre_en) begin
      env_mem[pre_addr] <= pre_data;
      env_v[pre_addr] <= 1'b1;
    end
  logic [15:0] ref_mem [0:65535];
  int n_vec = 0, n_err = 0, t = 0, free_at = 0, g = 0;
  bit act = 0, own = 0, last = 1, a_we = 0;
  logic [15:0] a_addr, a_wdata, a_rd, exp_rd = '0;
  bit cool [2];
  int order [$];
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, t);
    end
  endtask
  task automatic tick();
    bit acc, rsp, p;
    if (rst) begin
      act = 0; last = 1; exp_rd = '0; free_at = t + 1;
    end else if (t >= free_at && (req[0] || req[1])) begin
      p = (req[0] && req[1]) ? !last : req[1];
      act = 1; g = t; own = p; last = p;
      a_we = we[p]; a_addr = addr[p]; a_wdata = wdata[p]; a_rd = ref_mem[addr[p]];
      if (we[p]) ref_mem[addr[p]] = wdata[p];
      free_at = t + L + 2;
    end
    @(posedge clk); #1;
    t++;
    acc = act && t >= g + 1 && t <= g + L;
    rsp = act && t == g + L + 1;
    if (rsp && !a_we) exp_rd = a_rd;
    check("mem_en", mem_en, acc);
    if (acc) begin
      check("mem_addr", mem_addr, a_addr);
      check("mem_we", mem_we, a_we);
      check("mem_wdata", mem_wdata, a_wdata);
    end
    check("cpu_ready", rdy[0], rsp && !own);
    check("ldr_ready", rdy[1], rsp && own);
    check("grant_ldr", grant_ldr, (acc || rsp) && own);
    check("cpu_rdata", cpu_rdata, exp_rd);
    check("ldr_rdata", ldr_rdata, exp_rd);
    if (act && t >= g + L + 2) act = 0;
  endtask
  task automatic drive(int pct, int drop);
    for (int r = 0; r < 2; r++)
      if (rdy[r]) begin
        req[r] = 1'b0; cool[r] = 1;
      end else if (cool[r]) cool[r] = 0;
      else if (req[r]) begin
        if (act && own == (r == 1) && t > g) begin
          addr[r] = 16'($urandom); wdata[r] = 16'($urandom); we[r] = 1'($urandom);
          if ($urandom_range(0, 99) < drop) req[r] = 1'b0;
        end
      end else if ($urandom_range(0, 99) < pct) begin
        req[r] = 1'b1; we[r] = 1'($urandom_range(0, 1));
        addr[r] = 16'($urandom_range(0, 15)); wdata[r] = 16'($urandom);
      end
  endtask
  task automatic xfer(int r, logic w, logic [15:0] a, logic [15:0] d, output logic [15:0] rd);
    req[r] = 1'b1; we[r] = w; addr[r] = a; wdata[r] = d;
    for (int i = 0; i < 20 && !rdy[r]; i++) tick();
    check("xfer_done", rdy[r], 1);
    rd = r ? ldr_rdata : cpu_rdata;
    req[r] = 1'b0;
    tick();
  endtask
  initial begin
    logic [15:0] rd;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 16'(i) ^ 16'hA5C3;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    pre_en = 1'b1; pre_addr = 16'h3000; pre_data = 16'h1234; ref_mem[16'h3000] = 16'h1234;
    tick();
    pre_en = 1'b0;
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_mem_we", mem_we, 0);
    check("rst_u1_en", m1_en, 0);
    check("rst_u1_ready", l1_ready, 0);
    tick();
    rst = 1'b0;
    l1_req = 1'b1;
    tick();
    check("u1_en_c1", m1_en, 1);
    check("u1_addr_c1", m1_addr, 16'h0010);
    check("u1_ready_c1", l1_ready, 0);
    tick();
    check("u1_en_c2", m1_en, 0);
    check("u1_ready_c2", l1_ready, 1);
    check("u1_rdata", l1_rdata, 16'h00AA);
    check("u1_grant", g1_ldr, 1);
    l1_req = 1'b0;
    tick();
    check("u1_ready_c3", l1_ready, 0);
    check("u1_grant_c3", g1_ldr, 0);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h3000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 2) addr[0] = 16'h4000;
    end
    check("t1_ready", rdy[0], 1);
    check("t1_rdata", cpu_rdata, 16'h1234);
    check("t1_ldr_ready", rdy[1], 0);
    req[0] = 1'b0;
    tick();
    xfer(1, 1'b1, 16'h0200, 16'hBEEF, rd);
    xfer(0, 1'b0, 16'h0200, 16'h0000, rd);
    check("t2_readback", rd, 16'hBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cool[0] = 0; cool[1] = 0;
    req = 2'b11; we = 2'b00; addr[0] = 16'h0005; addr[1] = 16'h0006;
    for (int i = 0; i < 80 && order.size() < 4; i++) begin
      tick();
      if (rdy[0]) order.push_back(0);
      if (rdy[1]) order.push_back(1);
      drive(100, 0);
    end
    check("rr_count", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++) check("rr_order", order[i], i % 2);
    req = 2'b00;
    for (int i = 0; i < 8; i++) tick();
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0007;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cool[0] = 0; cool[1] = 0;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0008;
    tick();
    check("post_rst_cpu_first", grant_ldr, 0);
    check("post_rst_addr", mem_addr, 16'h0007);
    for (int i = 0; i < 40 && (req != 2'b00 || act); i++) begin
      drive(0, 0);
      tick();
    end
    check("post_rst_drained", req, 2'b00);
    for (int i = 0; i < 3000; i++) begin
      drive(35, 3);
      tick();
    end
    req = 2'b00;
    for (int i = 0; i < 10; i++) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
